polar64_crc16_decoder: RTL and testbench
========================================

# polar64_crc16_decoder

Hard-decision receive-side counterpart of the Polar (64,40) CRC-16 encoder. It accepts a 64-bit hard-decision codeword and recovers the bit vector u with a multi-cycle inverse polar transform, one butterfly stage per cycle. It then extracts the 24-bit payload and 16-bit CRC, recomputes CRC-16-CCITT byte-serially, and reports the payload with integrity flags. It sits directly after the channel/slicer in the loopback and verification path of the polar datapath.

## Interface
- No parameters. Code geometry is fixed: N=64, K=40, 24 payload bits, 16 CRC bits.
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse; honoured only when busy=0.
- codeword_in  input  64  hard-decision codeword; sampled on the accepting edge only.
- busy  output  1  high from the accepting edge until the edge that raises done.
- done  output  1  one-cycle pulse; data_out and the flags are valid from this cycle on.
- data_out  output  24  recovered payload; held until the next done.
- crc_ok  output  1  recomputed CRC equals received CRC; held until the next done.
- frozen_err  output  1  a frozen position of u is nonzero; held until the next done.

## Operation
- FSM states:
  - IDLE: wait for start.
  - XFORM: 6 cycles, stage counter s=0..5.
  - CRC: 3 cycles, byte counter b=0..2.
  - FIN: 1 cycle.
- IDLE & start: latch v<=codeword_in, set s=0, go to XFORM, busy<=1.
- XFORM, each cycle: for every i in 0..63 with bit s of i clear, v[i] <= v[i] ^ v[i|(1<<s)]; other bits unchanged.
  - After s=5, go to CRC.
  - After 6 stages, v equals polar_transform64(codeword_in). The transform is involutory over GF(2), so v is the encoder's u.
- On XFORM to CRC:
  - Extract payload and received CRC from the information set. Use exactly the positions and ordering that build_u in polar_common_pkg writes; extract_u is added to that package as the inverse of build_u.
  - Initialise the CRC register to the same init value as crc16_ccitt24.
- CRC, each cycle: fold one payload byte, MSB byte first, MSB-first bit order, polynomial 0x1021 (8 bit-steps unrolled per cycle). After b=2, go to FIN.
  - The result is bit-identical to crc16_ccitt24(payload).
- FIN:
  - Register data_out, crc_ok = (calc == rx_crc), and frozen_err = OR of v over the 24 frozen positions.
  - done<=1, busy<=0, return to IDLE.
- start while busy: ignored. No queueing, no restart, no effect on the in-flight decode.
- start in the same cycle done is high: accepted, because busy is already 0.
- No error correction. Any channel error shows up as crc_ok=0 and/or frozen_err=1. data_out is still the raw extraction.

## Timing
- Reset value of every output is 0: busy, done, data_out, crc_ok, frozen_err. The FSM resets to IDLE.
- Accepting edge E0: busy is high from E0.
- XFORM stages execute on E1..E6; CRC bytes on E7..E9.
- done rises on E10 and falls on E11. Latency is exactly 10 cycles from the accepting edge.
- Back-to-back throughput: one decode per 10 cycles (start on the done cycle).
- rst_n asserted mid-decode aborts immediately, all state returns to reset values, and no done pulse is produced. After rst_n deasserts, the first rising edge can accept start.
- Outputs only change on the FIN edge, never during XFORM or CRC.

## Configuration
- POLAR_DEC_FROZEN_CHECK_EN:
  - Defined: frozen_err is computed as described.
  - Undefined: frozen_err is tied to 0 and the frozen-bit OR logic is not synthesised. Latency, crc_ok and data_out are unchanged.

## Test plan
- Clean decode: codeword_in = encoder output for data_in=24'hA55A3C, then a start pulse. Required: done exactly 10 cycles later, data_out=24'hA55A3C, crc_ok=1, frozen_err=0.
- CRC corruption: the same codeword with bit 63 flipped. Required: crc_ok=0 or frozen_err=1 (at least one of the two); done still arrives at +10 cycles.
- Frozen-only error: u=build_u(24'h000001, crc16_ccitt24(24'h000001)) with frozen position 0 set, passed through polar_transform64 as the codeword. Required: data_out=24'h000001, crc_ok=1, frozen_err=1 (frozen_err=0 with the macro undefined).
- Busy rejection: start at E0 and again at E4 with a different codeword. Required: a single done at E10 carrying the first result; busy stays high E0..E9.
- Back-to-back: a second start on the done cycle, data 24'hFFFFFF. Required: second done exactly 10 cycles after the first with data_out=24'hFFFFFF and crc_ok=1.
- Reset mid-op: rst_n low at E5. Required: all outputs 0 immediately, no done pulse; a fresh start after release decodes correctly.

Source files
------------

// File: rtl/polar64_crc16_decoder_if.sv
// polar64_crc16_decoder_if: start/codeword request and payload/flag result bundle
interface polar64_crc16_decoder_if;
   logic        start;
   logic [63:0] codeword_in;
   logic        busy;
   logic        done;
   logic [23:0] data_out;
   logic        crc_ok;
   logic        frozen_err;
   modport master (output start, codeword_in, input busy, done, data_out, crc_ok, frozen_err);
   modport slave (input start, codeword_in, output busy, done, data_out, crc_ok, frozen_err);
endinterface

// File: rtl/polar64_crc16_decoder.sv
// polar64_crc16_decoder: hard-decision polar (64,40) inverse transform + CRC-16-CCITT check.
// Define POLAR_DEC_FROZEN_CHECK_EN to compute frozen_err; otherwise it is tied to 0.
module polar64_crc16_decoder (
   input logic clk,
   input logic rst_n,
   polar64_crc16_decoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XFORM, CRC, FIN} state_t;
   // Info set: index weight >= 4 plus weight-3 indices except 7 and 11; ascending index carries {payload, crc} MSB first
   localparam logic [63:0] INFO = 64'hFFFE_FEE8_FEE8_E000;
   state_t state, state_next;
   logic [2:0] cnt;
   logic [63:0] v, v_next;
   logic [39:0] m;
   logic [23:0] pay;
   logic [15:0] rx_crc, calc;
   logic [7:0] byte_sel;
   logic load, xf, xf_last, crc_step, fin, frz;
   logic busy, done, crc_ok, frozen_err;
   logic [23:0] data_out;
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int k = 7; k >= 0; k--) r = (r[15] ^ d[k]) ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
      return r;
   endfunction
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   always_comb
      state_next = state == IDLE  ? (bus.start ? XFORM : IDLE) :
                   state == XFORM ? (cnt == 3'd5 ? CRC : XFORM) :
                   state == CRC   ? (cnt == 3'd2 ? FIN : CRC) : IDLE;
   always_comb begin
      load     = state == IDLE && bus.start;
      xf       = state == XFORM;
      xf_last  = xf && cnt == 3'd5;
      crc_step = state == CRC;
      fin      = state == FIN;
   end
   always_comb begin
      logic [5:0] p, j;
      v_next = v;
      for (int i = 0; i < 64; i++) begin
         p = 6'(i);
         j = p | (6'd1 << cnt);
         v_next[p] = p[cnt] ? v[p] : v[p] ^ v[j];
      end
   end
   always_comb begin
      logic [5:0] k;
      m = '0;
      k = '0;
      for (int i = 0; i < 64; i++)
         if (INFO[6'(i)]) begin
            m[6'd39 - k] = v_next[6'(i)];
            k = k + 6'd1;
         end
   end
   assign byte_sel = cnt == 3'd0 ? pay[23:16] : cnt == 3'd1 ? pay[15:8] : pay[7:0];
`ifdef POLAR_DEC_FROZEN_CHECK_EN
   assign frz = |(v & ~INFO);
`else
   assign frz = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt        <= '0;
         v          <= '0;
         pay        <= '0;
         rx_crc     <= '0;
         calc       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         data_out   <= '0;
         crc_ok     <= 1'b0;
         frozen_err <= 1'b0;
      end else begin
         done <= fin;
         if (load) begin
            v    <= bus.codeword_in;
            cnt  <= '0;
            busy <= 1'b1;
         end
         if (xf) begin
            v   <= v_next;
            cnt <= xf_last ? 3'd0 : cnt + 3'd1;
         end
         if (xf_last) begin
            pay    <= m[39:16];
            rx_crc <= m[15:0];
            calc   <= 16'hFFFF;
         end
         if (crc_step) begin
            calc <= crc_byte(calc, byte_sel);
            cnt  <= cnt + 3'd1;
         end
         if (fin) begin
            busy       <= 1'b0;
            data_out   <= pay;
            crc_ok     <= calc == rx_crc;
            frozen_err <= frz;
         end
      end
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.data_out   = data_out;
   assign bus.crc_ok     = crc_ok;
   assign bus.frozen_err = frozen_err;
endmodule

// File: tb/tb_polar64_crc16_decoder.sv
// tb_polar64_crc16_decoder: directed decode vectors with a bench-side polar encoder for stimulus
module tb_polar64_crc16_decoder;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;
   localparam logic [63:0] INFO = 64'hFFFE_FEE8_FEE8_E000;
`ifdef POLAR_DEC_FROZEN_CHECK_EN
   localparam logic FZ = 1'b1;
`else
   localparam logic FZ = 1'b0;
`endif
   always #5 clk = ~clk;
   polar64_crc16_decoder_if bus ();
   polar64_crc16_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   function automatic logic [15:0] crc24(input logic [23:0] d);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      for (int k = 23; k >= 0; k--) begin
         fb = c[15] ^ d[k];
         c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction
   function automatic logic [63:0] build_u(input logic [23:0] d, input logic [15:0] c);
      logic [39:0] m;
      logic [63:0] u;
      int k;
      m = {d, c};
      u = '0;
      k = 39;
      for (int i = 0; i < 64; i++)
         if (INFO[i]) begin
            u[i] = m[k];
            k--;
         end
      return u;
   endfunction
   // x = u * G with G[i][j] = 1 when the bits of j are a subset of the bits of i
   function automatic logic [63:0] enc(input logic [63:0] u);
      logic [63:0] x;
      x = '0;
      for (int j = 0; j < 64; j++)
         for (int i = 0; i < 64; i++)
            if ((i & j) == j) x[j] = x[j] ^ u[i];
      return x;
   endfunction
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.done && n < 20);
   endtask
   task automatic pulse(input logic [63:0] cw);
      bus.codeword_in = cw;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask
   initial begin
      logic [63:0] cw_a, cw_f, u;
      int n, busy_cnt, done_cnt;
      cw_a = enc(build_u(24'hA55A3C, crc24(24'hA55A3C)));
      cw_f = enc(build_u(24'hFFFFFF, crc24(24'hFFFFFF)));
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.codeword_in = '0;
      tick();
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_data", bus.data_out, 0);
      check("rst_crc_ok", bus.crc_ok, 0);
      check("rst_frozen", bus.frozen_err, 0);
      rst_n = 1'b1;
      // clean decode
      pulse(cw_a);
      check("clean_busy_e0", bus.busy, 1);
      wait_done(n);
      check("clean_latency", n, 10);
      check("clean_data", bus.data_out, 24'hA55A3C);
      check("clean_crc_ok", bus.crc_ok, 1);
      check("clean_frozen", bus.frozen_err, 0);
      check("clean_busy_done", bus.busy, 0);
      tick();
      check("clean_done_fall", bus.done, 0);
      // bit 63 flip inverts every u bit
      pulse(cw_a ^ {1'b1, 63'b0});
      wait_done(n);
      check("corr_latency", n, 10);
      check("corr_data", bus.data_out, 24'h5AA5C3);
      check("corr_crc_ok", bus.crc_ok, crc24(24'h5AA5C3) == ~crc24(24'hA55A3C));
      check("corr_frozen", bus.frozen_err, FZ);
      check("corr_detect", bus.crc_ok == 1'b0 || bus.frozen_err == 1'b1, 1);
      tick();
      // frozen-only error
      u = build_u(24'h000001, crc24(24'h000001));
      u[0] = 1'b1;
      pulse(enc(u));
      wait_done(n);
      check("frz_latency", n, 10);
      check("frz_data", bus.data_out, 24'h000001);
      check("frz_crc_ok", bus.crc_ok, 1);
      check("frz_frozen", bus.frozen_err, FZ);
      tick();
      // busy rejection: second start sampled on E4
      pulse(cw_a);
      busy_cnt = bus.busy ? 1 : 0;
      for (int c = 1; c <= 9; c++) begin
         if (c == 4) begin
            bus.start = 1'b1;
            bus.codeword_in = cw_f;
         end
         tick();
         bus.start = 1'b0;
         if (bus.busy) busy_cnt++;
         if (bus.done) done_cnt++;
      end
      check("rej_busy_e0_e9", busy_cnt, 10);
      tick();
      check("rej_done_e10", bus.done, 1);
      check("rej_data", bus.data_out, 24'hA55A3C);
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.done) done_cnt++;
      end
      check("rej_no_extra_done", done_cnt, 0);
      // back-to-back: start on the done cycle
      pulse(cw_a);
      wait_done(n);
      check("b2b_first_latency", n, 10);
      check("b2b_first_data", bus.data_out, 24'hA55A3C);
      check("b2b_start_ok_busy", bus.busy, 0);
      pulse(cw_f);
      check("b2b_busy_e0", bus.busy, 1);
      wait_done(n);
      check("b2b_second_latency", n, 10);
      check("b2b_second_data", bus.data_out, 24'hFFFFFF);
      check("b2b_second_crc_ok", bus.crc_ok, 1);
      check("b2b_second_frozen", bus.frozen_err, 0);
      tick();
      // reset mid-decode
      pulse(cw_a);
      for (int c = 1; c <= 5; c++) tick();
      check("mid_outputs_held", bus.data_out, 24'hFFFFFF);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_data", bus.data_out, 0);
      check("mid_rst_crc_ok", bus.crc_ok, 0);
      check("mid_rst_frozen", bus.frozen_err, 0);
      tick();
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (bus.done) done_cnt++;
      end
      check("mid_no_done", done_cnt, 0);
      pulse(cw_f);
      wait_done(n);
      check("post_rst_latency", n, 10);
      check("post_rst_data", bus.data_out, 24'hFFFFFF);
      check("post_rst_crc_ok", bus.crc_ok, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
